// File: rtl/sdram_arbiter_rr_pkg.sv
// Shared constants, slot record and id helper for the SDRAM request arbiter.
// Id 0 on the controller side means "no request"; master i travels as id i+1.
package sdram_arb_pkg;

  localparam int SDRAM_ARB_NUM_MASTERS = 4;
  localparam int SDRAM_ARB_ADDR_W      = 26;
  localparam int SDRAM_ARB_DATA_W      = 32;
  localparam int SDRAM_ARB_BE_W        = SDRAM_ARB_DATA_W / 8;
  localparam int SDRAM_ARB_ID_W        = $clog2(SDRAM_ARB_NUM_MASTERS + 1);

  localparam int SDRAM_ID_IDLE = 0;

  typedef struct packed {
    logic [SDRAM_ARB_ID_W-1:0]   id;
    logic [SDRAM_ARB_ADDR_W-1:0] addr;
    logic                        write;
    logic                        burst;
    logic [SDRAM_ARB_BE_W-1:0]   byte_enable;
    logic [SDRAM_ARB_DATA_W-1:0] wdata;
  } sdram_slot_t;

  function automatic int id_of(input int index);
    return index + 1;
  endfunction

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Winner selection among N requesters. Round-robin starting after last_grant_i
// when SDRAM_ARB_ROUND_ROBIN_EN is defined, otherwise lowest index wins.
module arb_rr_picker
  import sdram_arb_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0] last_grant_i,
`endif
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] index_o
);

  // Walk candidates in priority order; the first requester seen takes the grant.
  always_comb begin : pick_b
    logic             taken;
    logic [IDX_W-1:0] cand;
    taken   = 1'b0;
    cand    = '0;
    grant_o = '0;
    index_o = '0;
    for (int k = 0; k < N; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      cand = IDX_W'((int'(last_grant_i) + 1 + k) % N);
`else
      cand = IDX_W'(k);
`endif
      grant_o[cand] = req_i[cand] & ~taken;
      index_o       = (req_i[cand] && !taken) ? cand : index_o;
      taken         = taken | req_i[cand];
    end
  end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// N-master arbiter holding one registered request slot toward the SDRAM controller.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority.
module sdram_arbiter_rr
  import sdram_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  parameter  int ADDR_W      = 26,
  parameter  int DATA_W      = 32,
  localparam int ID_W        = $clog2(NUM_MASTERS + 1),
  localparam int BE_W        = DATA_W / 8
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic [ID_W-1:0]                     sdram_req,
  output logic [ADDR_W-1:0]                   sdram_addr,
  output logic                                sdram_write,
  output logic                                sdram_burst,
  output logic [BE_W-1:0]                     sdram_byte_enable,
  output logic [DATA_W-1:0]                   sdram_wdata,
  input  logic                                sdram_ack,
  input  logic [DATA_W-1:0]                   sdram_rdata,
  input  logic [ID_W-1:0]                     sdram_rdvalid,
  input  logic                                sdram_complete,
  input  logic [NUM_MASTERS-1:0]              m_request,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
  input  logic [NUM_MASTERS-1:0]              m_write,
  input  logic [NUM_MASTERS-1:0]              m_burst,
  input  logic [NUM_MASTERS-1:0][BE_W-1:0]    m_byte_enable,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic [NUM_MASTERS-1:0]              m_rdvalid,
  output logic [NUM_MASTERS-1:0]              m_complete,
  output logic                                protocol_error
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [ID_W-1:0]   req_q,   req_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              write_q, write_d;
  logic              burst_q, burst_d;
  logic [BE_W-1:0]   be_q,    be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q,   err_d;

  logic                   slot_free_s;
  logic                   grant_en_s;
  logic                   ack_idle_s;
  logic                   rdvalid_bad_s;
  logic [NUM_MASTERS-1:0] pick_grant_s;
  logic [IDX_W-1:0]       pick_index_s;

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
`endif

  arb_rr_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req_i        (m_request),
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_o      (pick_grant_s),
    .index_o      (pick_index_s)
  );

  // An ack frees the slot in the same cycle, so a waiting master refills it without a bubble.
  assign slot_free_s   = (req_q == ID_W'(SDRAM_ID_IDLE)) | sdram_ack;
  assign grant_en_s    = slot_free_s & (|m_request) & ~reset;
  assign ack_idle_s    = sdram_ack & (req_q == ID_W'(SDRAM_ID_IDLE));
  assign rdvalid_bad_s = (sdram_rdvalid > ID_W'(NUM_MASTERS));

  assign m_ack = grant_en_s ? pick_grant_s : '0;

  // Slot next state: load the winner, clear on an ack with nobody waiting, else hold.
  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    write_d = write_q;
    burst_d = burst_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q | ack_idle_s | rdvalid_bad_s;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    if (grant_en_s) begin
      req_d   = ID_W'(id_of(int'(pick_index_s)));
      addr_d  = m_addr[pick_index_s];
      write_d = m_write[pick_index_s];
      burst_d = m_burst[pick_index_s];
      be_d    = m_byte_enable[pick_index_s];
      wdata_d = m_wdata[pick_index_s];
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant_d = pick_index_s;
`endif
    end else if (sdram_ack) begin
      req_d   = ID_W'(SDRAM_ID_IDLE);
      addr_d  = '0;
      write_d = 1'b0;
      burst_d = 1'b0;
      be_d    = '0;
      wdata_d = '0;
    end else begin
      req_d = req_q;
    end
  end

  // Slot and error registers; reset drops any request in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q   <= ID_W'(SDRAM_ID_IDLE);
      addr_q  <= '0;
      write_q <= 1'b0;
      burst_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= IDX_W'(NUM_MASTERS - 1);
`endif
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      burst_q <= burst_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Read return is purely combinational and stays live through reset.
  always_comb begin
    m_rdvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_rdvalid[i] = (sdram_rdvalid == ID_W'(id_of(i)));
    end
  end

  assign m_complete = m_rdvalid & {NUM_MASTERS{sdram_complete}};
  assign m_rdata    = sdram_rdata;

  assign sdram_req         = req_q;
  assign sdram_addr        = addr_q;
  assign sdram_write       = write_q;
  assign sdram_burst       = burst_q;
  assign sdram_byte_enable = be_q;
  assign sdram_wdata       = wdata_q;
  assign protocol_error    = err_q;

endmodule

// File: tb/tb_sdram_arbiter_rr.sv
// Self-checking bench for sdram_arbiter_rr: vector table, corner sequences and
// randomized traffic against a priority-list reference model.
module tb_sdram_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int IW = 3;

  logic                clock;
  logic                reset;
  logic [IW-1:0]       sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_write;
  logic                sdram_burst;
  logic [BW-1:0]       sdram_byte_enable;
  logic [DW-1:0]       sdram_wdata;
  logic                sdram_ack;
  logic [DW-1:0]       sdram_rdata;
  logic [IW-1:0]       sdram_rdvalid;
  logic                sdram_complete;
  logic [N-1:0]        m_request;
  logic [N-1:0][AW-1:0] m_addr;
  logic [N-1:0]        m_write;
  logic [N-1:0]        m_burst;
  logic [N-1:0][BW-1:0] m_byte_enable;
  logic [N-1:0][DW-1:0] m_wdata;
  logic [N-1:0]        m_ack;
  logic [DW-1:0]       m_rdata;
  logic [N-1:0]        m_rdvalid;
  logic [N-1:0]        m_complete;
  logic                protocol_error;

  int n_pass;
  int n_total;

  sdram_arbiter_rr #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_write(sdram_write),
    .sdram_burst(sdram_burst), .sdram_byte_enable(sdram_byte_enable),
    .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack), .sdram_rdata(sdram_rdata),
    .sdram_rdvalid(sdram_rdvalid), .sdram_complete(sdram_complete),
    .m_request(m_request), .m_addr(m_addr), .m_write(m_write), .m_burst(m_burst),
    .m_byte_enable(m_byte_enable), .m_wdata(m_wdata), .m_ack(m_ack),
    .m_rdata(m_rdata), .m_rdvalid(m_rdvalid), .m_complete(m_complete),
    .protocol_error(protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  req;
    logic          ack;
    logic [IW-1:0] rdv;
    logic          cmp;
    logic [DW-1:0] rdata;
    logic [N-1:0]  e_ack;
    logic [N-1:0]  e_rdv;
    logic [N-1:0]  e_cmp;
    logic [IW-1:0] e_req;
    logic          e_err;
  } vec_t;

  vec_t vecs[19];

  // Reference model: pending slot plus a priority list that rotates after each grant.
  int          mdl_id;
  logic [AW-1:0] mdl_addr;
  logic        mdl_write;
  logic        mdl_burst;
  logic [BW-1:0] mdl_be;
  logic [DW-1:0] mdl_wdata;
  logic        mdl_err;
  int          prio[$];

  task automatic mdl_reset();
    mdl_id = 0; mdl_addr = '0; mdl_write = 1'b0; mdl_burst = 1'b0;
    mdl_be = '0; mdl_wdata = '0; mdl_err = 1'b0;
    prio = {};
    for (int i = 0; i < N; i++) prio.push_back(i);
  endtask

  function automatic int mdl_pick(input logic [N-1:0] req);
    int w;
    w = -1;
    foreach (prio[j]) begin
      if (w < 0 && req[prio[j][1:0]]) w = prio[j];
    end
    return w;
  endfunction

  task automatic mdl_granted(input int w);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    prio = {};
    for (int k = 1; k <= N; k++) prio.push_back((w + k) % N);
`else
    if (w < 0) prio = prio;
`endif
  endtask

  task automatic idle_inputs();
    m_request = '0; sdram_ack = 1'b0; sdram_rdvalid = '0;
    sdram_complete = 1'b0; sdram_rdata = '0;
  endtask

  int          got[5];
  int          exp_order[5];
  int          w;
  logic [N-1:0] exp_ack;
  logic [N-1:0] req_hold;
  logic [N-1:0] e_rdv;
  logic         free;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      m_addr[i] = AW'(32'h0010_0000 + i); m_write[i] = 1'(i % 2); m_burst[i] = 1'(i / 2);
      m_byte_enable[i] = BW'(i + 1); m_wdata[i] = DW'(32'hA000_0000 + i);
    end

    //              rst  req     ack  rdv   cmp   rdata          e_ack   e_rdv   e_cmp   e_req e_err
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 3'd2, 1'b1, 32'h1111_2222, 4'b0000, 4'b0010, 4'b0010, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0001, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1110, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0100, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0100, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd3, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b0, 3'd3, 1'b1, 32'hDEAD_BEEF, 4'b0000, 4'b0100, 4'b0100, 3'd0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b0, 3'd1, 1'b0, 32'h1234_5678, 4'b0000, 4'b0001, 4'b0000, 3'd0, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0001, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 4'b0010, 1'b1, 3'd0, 1'b0, 32'h0,         4'b0010, 4'b0000, 4'b0000, 3'd1, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd2, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd2, 1'b0};
    vecs[15] = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[16] = '{1'b0, 4'b0000, 1'b1, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b0};
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 3'd0, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 3'd0, 1'b1};
    vecs[18] = '{1'b0, 4'b0000, 1'b0, 3'd4, 1'b1, 32'hCAFE_F00D, 4'b0000, 4'b1000, 4'b1000, 3'd0, 1'b1};

    // First reset cycle unchecked; the table's first row is the second reset cycle.
    @(posedge clock); #1;
    for (int v = 0; v < 19; v++) begin
      @(posedge clock); #1;
      reset = vecs[v].rst; m_request = vecs[v].req; sdram_ack = vecs[v].ack;
      sdram_rdvalid = vecs[v].rdv; sdram_complete = vecs[v].cmp; sdram_rdata = vecs[v].rdata;
      @(negedge clock);
      chk($sformatf("vec%0d m_ack", v), 64'(m_ack), 64'(vecs[v].e_ack));
      chk($sformatf("vec%0d m_rdvalid", v), 64'(m_rdvalid), 64'(vecs[v].e_rdv));
      chk($sformatf("vec%0d m_complete", v), 64'(m_complete), 64'(vecs[v].e_cmp));
      chk($sformatf("vec%0d m_rdata", v), 64'(m_rdata), 64'(vecs[v].rdata));
      chk($sformatf("vec%0d sdram_req", v), 64'(sdram_req), 64'(vecs[v].e_req));
      chk($sformatf("vec%0d protocol_error", v), 64'(protocol_error), 64'(vecs[v].e_err));
      if (vecs[v].rst) begin
        chk("reset slot fields", {sdram_addr, sdram_write, sdram_burst, sdram_byte_enable, sdram_wdata[0]},
            64'h0);
        chk("reset wdata", 64'(sdram_wdata), 64'h0);
      end
    end

    // Error flag clears only by reset; out-of-range read id raises it without routing.
    @(posedge clock); #1; idle_inputs(); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0; sdram_rdvalid = 3'd7; sdram_complete = 1'b1;
    @(negedge clock);
    chk("err cleared by reset", 64'(protocol_error), 64'h0);
    chk("rdvalid7 m_rdvalid", 64'(m_rdvalid), 64'h0);
    chk("rdvalid7 m_complete", 64'(m_complete), 64'h0);
    @(posedge clock); #1; sdram_rdvalid = '0; sdram_complete = 1'b0;
    @(negedge clock);
    chk("rdvalid7 protocol_error", 64'(protocol_error), 64'h1);

    // Fairness with continuous requests and immediate acks: grant every cycle, no gaps.
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif
    @(posedge clock); #1; idle_inputs(); reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      reset = 1'b0; m_request = 4'b1111; sdram_ack = (sdram_req != 3'd0);
      @(negedge clock);
      got[k] = -1;
      for (int i = 0; i < N; i++) if (m_ack[i]) got[k] = i;
      chk($sformatf("fair grant%0d", k), 64'(got[k]), 64'(exp_order[k]));
      if (k > 0) chk($sformatf("fair sdram_req%0d", k), 64'(sdram_req), 64'(exp_order[k-1] + 1));
    end

    // Randomized traffic against the reference model.
    @(posedge clock); #1; idle_inputs(); reset = 1'b1;
    @(posedge clock); #1;
    mdl_reset();
    req_hold = '0; exp_ack = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      reset = ($urandom_range(0, 99) == 0);
      req_hold = (req_hold & ~exp_ack) | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
      m_request = req_hold;
      sdram_ack = (mdl_id != 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 299) == 0);
      sdram_rdvalid = ($urandom_range(0, 199) == 0) ? IW'($urandom_range(5, 7)) : IW'($urandom_range(0, 4));
      sdram_complete = 1'($urandom_range(0, 1));
      sdram_rdata = $urandom;
      for (int i = 0; i < N; i++) begin
        m_addr[i] = AW'($urandom); m_write[i] = 1'($urandom_range(0, 1));
        m_burst[i] = 1'($urandom_range(0, 1)); m_byte_enable[i] = BW'($urandom);
        m_wdata[i] = $urandom;
      end
      @(negedge clock);
      chk("rnd sdram_req", 64'(sdram_req), 64'(mdl_id));
      chk("rnd slot", {sdram_addr, sdram_write, sdram_burst, sdram_byte_enable},
          {mdl_addr, mdl_write, mdl_burst, mdl_be});
      chk("rnd wdata", 64'(sdram_wdata), 64'(mdl_wdata));
      chk("rnd protocol_error", 64'(protocol_error), 64'(mdl_err));
      free = (mdl_id == 0) || sdram_ack;
      w = mdl_pick(m_request);
      exp_ack = (!reset && free && w >= 0) ? N'(1 << w) : '0;
      e_rdv = (sdram_rdvalid >= 1 && sdram_rdvalid <= N) ? N'(1 << (sdram_rdvalid - 1)) : '0;
      chk("rnd m_ack", 64'(m_ack), 64'(exp_ack));
      chk("rnd m_rdvalid", 64'(m_rdvalid), 64'(e_rdv));
      chk("rnd m_complete", 64'(m_complete), 64'(sdram_complete ? e_rdv : '0));
      chk("rnd m_rdata", 64'(m_rdata), 64'(sdram_rdata));
      if (reset) begin
        mdl_reset();
      end else begin
        if ((sdram_ack && mdl_id == 0) || sdram_rdvalid > N) mdl_err = 1'b1;
        if (exp_ack != '0) begin
          mdl_id = w + 1; mdl_addr = m_addr[w[1:0]]; mdl_write = m_write[w[1:0]];
          mdl_burst = m_burst[w[1:0]]; mdl_be = m_byte_enable[w[1:0]]; mdl_wdata = m_wdata[w[1:0]];
          mdl_granted(w);
        end else if (sdram_ack) begin
          mdl_id = 0; mdl_addr = '0; mdl_write = 1'b0; mdl_burst = 1'b0; mdl_be = '0; mdl_wdata = '0;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
